// File: rtl/patch_streamer.sv
// patch_streamer: waits for a finished patchifier frame (patch_state DONE),
// snapshots the patch array, acknowledges it with a one-cycle output_taken
// pulse, then streams the patches one pixel per beat in patch-major order
// over a valid/ready interface.
// Optional feature macro: PATCH_CLS_TOKEN_EN -- prepends a CLS token of
// PATCH_VECTOR_SIZE beats of CLS_PIXEL and shifts patch k to token k+1.
module patch_streamer #(
    parameter int PIXEL_WIDTH       = 24,
    parameter int TOTAL_NUM_PATCHES = 16,
    parameter int PATCH_VECTOR_SIZE = 16,
    parameter logic [PIXEL_WIDTH-1:0] CLS_PIXEL = '0,
    parameter int IDX_W = $clog2(TOTAL_NUM_PATCHES + 1),
    parameter int POS_W = $clog2(PATCH_VECTOR_SIZE)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic [2:0]             patch_state,
    input  logic [PIXEL_WIDTH-1:0] all_patches [TOTAL_NUM_PATCHES][PATCH_VECTOR_SIZE],
    output logic                   output_taken,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PIXEL_WIDTH-1:0] out_data,
    output logic [IDX_W-1:0]       out_patch_idx,
    output logic [POS_W-1:0]       out_pos_idx,
    output logic                   out_last_pix,
    output logic                   out_last,
    output logic                   busy,
    output logic                   frame_done
);

    localparam logic [2:0] PATCH_DONE = 3'b100;
    localparam int PSEL_W = (TOTAL_NUM_PATCHES > 1) ? $clog2(TOTAL_NUM_PATCHES) : 1;

`ifdef PATCH_CLS_TOKEN_EN
    localparam int LAST_TOK = TOTAL_NUM_PATCHES;
`else
    localparam int LAST_TOK = TOTAL_NUM_PATCHES - 1;
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        STREAM  = 2'd2,
        FIN     = 2'd3
    } state_t;

    state_t state, next_state;

    logic [PIXEL_WIDTH-1:0] patch_buf [TOTAL_NUM_PATCHES][PATCH_VECTOR_SIZE];
    logic [IDX_W-1:0]       p;
    logic [POS_W-1:0]       q;
    logic [PSEL_W-1:0]      patch_sel;
    logic                   start;
    logic                   transfer;
    logic                   last_pix;
    logic                   last_beat;
    logic                   cls_beat;

    assign start     = (state == IDLE) && en && (patch_state == PATCH_DONE);
    assign transfer  = (state == STREAM) && out_ready;
    assign last_pix  = (q == POS_W'(PATCH_VECTOR_SIZE - 1));
    assign last_beat = last_pix && (p == IDX_W'(LAST_TOK));

`ifdef PATCH_CLS_TOKEN_EN
    // Token 0 is the CLS token; patch k sits at token k+1. During the CLS
    // token the wrapped select is harmless because cls_beat overrides it.
    assign cls_beat  = (p == '0);
    assign patch_sel = PSEL_W'(p - IDX_W'(1));
`else
    assign cls_beat  = 1'b0;
    assign patch_sel = PSEL_W'(p);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic and control outputs
    always_comb begin
        next_state   = state;
        output_taken = 1'b0;
        out_valid    = 1'b0;
        frame_done   = 1'b0;
        busy         = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) next_state = CAPTURE;
            end
            CAPTURE: begin
                output_taken = 1'b1;
                next_state   = STREAM;
            end
            STREAM: begin
                out_valid = 1'b1;
                if (transfer && last_beat) next_state = FIN;
            end
            FIN: begin
                frame_done = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Snapshot of the patch array, taken on the DONE-sample edge; not reset
    always_ff @(posedge clk) begin
        if (start && !reset) patch_buf <= all_patches;
    end

    // Token / position counters, cleared at capture, advanced per transfer
    always_ff @(posedge clk) begin
        if (reset) begin
            p <= '0;
            q <= '0;
        end else if (state == CAPTURE) begin
            p <= '0;
            q <= '0;
        end else if (transfer) begin
            if (last_pix) begin
                q <= '0;
                p <= p + IDX_W'(1);
            end else begin
                q <= q + POS_W'(1);
            end
        end
    end

    // Beat outputs from the snapshot and counters, forced to 0 outside STREAM
    always_comb begin
        out_data      = '0;
        out_patch_idx = '0;
        out_pos_idx   = '0;
        out_last_pix  = 1'b0;
        out_last      = 1'b0;
        if (state == STREAM) begin
            out_data      = cls_beat ? CLS_PIXEL : patch_buf[patch_sel][q];
            out_patch_idx = p;
            out_pos_idx   = q;
            out_last_pix  = last_pix;
            out_last      = last_beat;
        end
    end

endmodule

// File: tb/tb_patch_streamer.sv
// Directed testbench for patch_streamer; expectations adapt to the
// PATCH_CLS_TOKEN_EN build option.
module tb_patch_streamer;

    localparam int PW = 24;
    localparam int NP = 16;
    localparam int PV = 16;
    localparam int IW = $clog2(NP + 1);
    localparam int QW = $clog2(PV);
    localparam logic [PW-1:0] CLS_VAL = 24'hABCDEF;
`ifdef PATCH_CLS_TOKEN_EN
    localparam int NTOK = NP + 1;
    localparam int CLS  = 1;
`else
    localparam int NTOK = NP;
    localparam int CLS  = 0;
`endif
    localparam int NB = NTOK * PV;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic [2:0]    patch_state;
    logic [PW-1:0] ap [NP][PV];
    logic          output_taken;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_data;
    logic [IW-1:0] out_patch_idx;
    logic [QW-1:0] out_pos_idx;
    logic          out_last_pix;
    logic          out_last;
    logic          busy;
    logic          frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    patch_streamer #(
        .PIXEL_WIDTH      (PW),
        .TOTAL_NUM_PATCHES(NP),
        .PATCH_VECTOR_SIZE(PV),
        .CLS_PIXEL        (CLS_VAL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .patch_state  (patch_state),
        .all_patches  (ap),
        .output_taken (output_taken),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_patch_idx(out_patch_idx),
        .out_pos_idx  (out_pos_idx),
        .out_last_pix (out_last_pix),
        .out_last     (out_last),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] pix(input int unsigned seed, input int unsigned p,
                                          input int unsigned q);
        return PW'((seed << 16) | (p << 8) | q);
    endfunction

    task automatic load(input int unsigned seed);
        for (int unsigned i = 0; i < NP; i++)
            for (int unsigned j = 0; j < PV; j++)
                ap[i][j] = pix(seed, i, j);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge just before the capture edge. Checks the ack, then
    // every streamed beat against the model. Stalled cycles re-check the same
    // beat, so any drift while stalled is caught. stop_after>0 aborts with
    // reset once that many beats have been accepted.
    task automatic stream_frame(input int unsigned seed, input bit hold_done, input bit bp,
                                input bit scramble, input int unsigned stop_after,
                                input string name);
        int unsigned b = 0;
        int unsigned cyc = 0;
        int unsigned t, q;
        bit done = 1'b0;
        logic [PW-1:0] ed;
        logic el, elp;
        @(negedge clk);
        check({name, ":ack"}, 32'({output_taken, out_valid, busy}), 32'b101);
        if (!hold_done) patch_state = 3'b000;
        if (scramble)
            for (int unsigned i = 0; i < NP; i++)
                for (int unsigned j = 0; j < PV; j++)
                    ap[i][j] = PW'($urandom);
        out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        while (!done && cyc < 4 * NB + 20) begin
            @(negedge clk);
            cyc++;
            t   = b / PV;
            q   = b % PV;
            ed  = (CLS == 1 && t == 0) ? CLS_VAL : pix(seed, t - CLS, q);
            elp = (q == PV - 1);
            el  = elp && (t == NTOK - 1);
            check({name, ":ctl"}, 32'({out_valid, output_taken, frame_done, busy, out_last_pix, out_last}),
                  32'({4'b1001, elp, el}));
            check({name, ":data"}, 32'(out_data), 32'(ed));
            check({name, ":idx"}, 32'({out_patch_idx, out_pos_idx}), 32'({IW'(t), QW'(q)}));
            if (stop_after != 0 && b == stop_after) begin
                reset = 1'b1;
                @(negedge clk);
                check({name, ":abort_ctl"}, 32'({output_taken, out_valid, busy, frame_done, out_last_pix, out_last}), 32'd0);
                check({name, ":abort_data"}, 32'({out_data, out_patch_idx}), 32'd0);
                reset = 1'b0;
                return;
            end
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) begin
                if (b == NB - 1) done = 1'b1;
                b++;
            end
        end
        check({name, ":beats"}, 32'(b), 32'(NB));
        if (done) begin
            @(negedge clk);
            check({name, ":fin"}, 32'({out_valid, frame_done, busy, output_taken}), 32'b0110);
            patch_state = 3'b000;
            @(negedge clk);
            check({name, ":idle"}, 32'({out_valid, frame_done, busy, output_taken}), 32'b0000);
        end
    endtask

    initial begin
        reset       = 1'b1;
        en          = 1'b0;
        patch_state = 3'b000;
        out_ready   = 1'b0;
        load(0);
        repeat (2) @(negedge clk);
        check("reset_ctl", 32'({output_taken, out_valid, busy, frame_done, out_last_pix, out_last}), 32'd0);
        check("reset_data", 32'({out_data, out_pos_idx}), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_ctl", 32'({output_taken, out_valid, busy, frame_done}), 32'd0);

        // Full frame, DONE held, no backpressure
        en          = 1'b1;
        patch_state = 3'b100;
        stream_frame(0, 1'b1, 1'b0, 1'b0, 0, "t1");

        // Random backpressure
        load(1);
        patch_state = 3'b100;
        stream_frame(1, 1'b0, 1'b1, 1'b0, 0, "t2");

        // en low: DONE ignored
        en          = 1'b0;
        patch_state = 3'b100;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("t3_en_low", 32'({output_taken, out_valid, busy}), 32'd0);
        end
        load(2);
        en = 1'b1;
        stream_frame(2, 1'b0, 1'b0, 1'b0, 0, "t3");

        // Reset after 100 beats, then a clean restart
        load(3);
        patch_state = 3'b100;
        stream_frame(3, 1'b0, 1'b1, 1'b0, 100, "t4abort");
        @(negedge clk);
        check("t4_post_idle", 32'({output_taken, out_valid, busy}), 32'd0);
        load(0);
        patch_state = 3'b100;
        stream_frame(0, 1'b0, 1'b0, 1'b0, 0, "t4restart");

        // Input scrambled after capture
        load(1);
        patch_state = 3'b100;
        stream_frame(1, 1'b0, 1'b1, 1'b1, 0, "t5");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
